bcd_display_scheduler: RTL

//  Shares one combinational binary-to-BCD converter (6-bit in, ones/tens out) between the

---
 rtl/bcd_display_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/bcd_display_scheduler.sv
// -----------------------------------------------------------------------------
// bcd_display_scheduler
//
// Shares one external combinational binary-to-BCD converter between the score
// counter and the countdown timer. Each result is latched into a four-digit
// BCD bank, and the bank is time-multiplexed onto a four-digit seven-segment
// display.
//
// Parameters
//   REFRESH_DIV  clk cycles each digit stays on the display (>= 2)
//   BLANK_LZ     1: a tens digit of value 0 is blanked (all anodes high)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   score_req    level request to convert score_val, held until score_ack
//   score_val    score, 0..63
//   score_ack    one-cycle pulse: score digits updated this cycle
//   time_req     level request to convert time_val, held until time_ack
//   time_val     seconds remaining, 0..63
//   time_ack     one-cycle pulse: time digits updated this cycle
//   conv_inp     registered operand presented to the converter
//   conv_ones    converter ones digit
//   conv_tens    converter tens digit
//   busy         a conversion is in flight (SETUP or LATCH)
//   disp_digit   BCD digit currently shown
//   an           active-low one-hot anode select
// -----------------------------------------------------------------------------
module bcd_display_scheduler #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       score_req,
  input  logic [5:0] score_val,
  output logic       score_ack,
  input  logic       time_req,
  input  logic [5:0] time_val,
  output logic       time_ack,
  output logic [5:0] conv_inp,
  input  logic [3:0] conv_ones,
  input  logic [3:0] conv_tens,
  output logic       busy,
  output logic [3:0] disp_digit,
  output logic [3:0] an
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  typedef enum logic {
    SRC_SCORE = 1'b0,
    SRC_TIME  = 1'b1
  } src_t;

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  state_t state, state_nxt;
  src_t   owner, last_grant, grant_src;
  logic   grant;

  logic [3:0] score_ones, score_tens, time_ones, time_tens;

  // ---------------------------------------------------------------------------
  // Conversion FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours; = here would create order-dependent
  // simulation that does not match the synthesized netlist.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM: next-state and grant arbitration
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_src = SRC_SCORE;
    unique case (state)
      S_IDLE: begin
        if (score_req && time_req) begin
          // Round-robin: hand the converter to whoever was not served last.
          grant     = 1'b1;
          grant_src = (last_grant == SRC_SCORE) ? SRC_TIME : SRC_SCORE;
        end else if (score_req) begin
          grant     = 1'b1;
          grant_src = SRC_SCORE;
        end else if (time_req) begin
          grant     = 1'b1;
          grant_src = SRC_TIME;
        end
        if (grant) state_nxt = S_SETUP;
      end
      S_SETUP: state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state == S_SETUP) || (state == S_LATCH);
  end

  // ---------------------------------------------------------------------------
  // Operand, digit bank and acknowledge registers
  // ---------------------------------------------------------------------------
  // conv_inp is stable for the whole SETUP cycle, so the converter output is
  // settled by the SETUP->LATCH edge. Capturing on that edge makes the new
  // digits and the ack visible during LATCH, two cycles after the grant.
  // NOTE: the digit bank is only four small registers, so it is reset with
  // everything else; a reset aborting a conversion must also clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_inp   <= '0;
      owner      <= SRC_SCORE;
      last_grant <= SRC_TIME;
      score_ack  <= 1'b0;
      time_ack   <= 1'b0;
      score_ones <= '0;
      score_tens <= '0;
      time_ones  <= '0;
      time_tens  <= '0;
    end else begin
      score_ack <= 1'b0;
      time_ack  <= 1'b0;

      if (grant) begin
        conv_inp <= (grant_src == SRC_TIME) ? time_val : score_val;
        owner    <= grant_src;
      end

      if (state == S_SETUP) begin
        if (owner == SRC_SCORE) begin
          score_ones <= conv_ones;
          score_tens <= conv_tens;
          score_ack  <= 1'b1;
        end else begin
          time_ones <= conv_ones;
          time_tens <= conv_tens;
          time_ack  <= 1'b1;
        end
        last_grant <= owner;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx, idx_nxt;
  logic             wrap;
  logic [3:0]       slot_digit;
  logic             blank;
  logic [3:0]       an_nxt;

  // an and disp_digit are computed from the index the scan will hold after
  // this edge, so they change together with idx. They are re-evaluated every
  // cycle, so a digit updated mid-slot appears on the following clock.
  always_comb begin
    wrap    = (cnt == CNT_MAX);
    idx_nxt = wrap ? idx + 2'd1 : idx;
    unique case (idx_nxt)
      2'd0:    slot_digit = score_ones;
      2'd1:    slot_digit = score_tens;
      2'd2:    slot_digit = time_ones;
      default: slot_digit = time_tens;
    endcase
    // Odd slots carry tens digits.
    blank  = BLANK_LZ && idx_nxt[0] && (slot_digit == 4'd0);
    an_nxt = blank ? 4'b1111 : ~(4'b0001 << idx_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      an         <= 4'b1110;
      disp_digit <= 4'd0;
    end else begin
      cnt        <= wrap ? '0 : cnt + 1'b1;
      idx        <= idx_nxt;
      an         <= an_nxt;
      disp_digit <= slot_digit;
    end
  end

endmodule
